// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Core-wide constants shared by the execution-stage blocks.
//   DATA_WIDTH : architectural register / datapath width.
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int DATA_WIDTH = 32;

endpackage : core_pkg

// File: rtl/mdu_control_pkg.sv
// ----------------------------------------------------------------------------
// mdu_control_pkg
// Operation encoding for the multiply/divide unit. The code is the RV32M
// funct3 field, so bit 2 selects the divide family, bit 1 selects remainder
// within that family and bit 0 selects the unsigned variant.
//   MDU_WIDTH_CODE : width of the mdu_control operation code.
//   mdu_op_t       : operation encoding.
//   is_div()       : operation uses the iterative divider.
//   is_signed_div(): divide/remainder on two's-complement operands.
// ----------------------------------------------------------------------------
package mdu_control_pkg;

    localparam int MDU_WIDTH_CODE = 3;

    typedef enum logic [MDU_WIDTH_CODE-1:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    function automatic logic is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_div(input mdu_op_t op);
        return op[2] & ~op[0];
    endfunction

endpackage : mdu_control_pkg

// File: rtl/core_mdu_divider.sv
// ----------------------------------------------------------------------------
// core_mdu_divider
// Iterative radix-2 restoring divider on unsigned operands. One quotient bit
// is produced per cycle over DATA_WIDTH cycles after the load cycle.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset.
//   i_div_start     : one-cycle pulse, loads the operands and starts.
//   i_div_abort     : drops the operation in flight (higher priority).
//   i_dividend      : unsigned dividend.
//   i_divisor       : unsigned divisor (non-zero; zero is handled upstream).
//   o_div_done      : high during the final iteration cycle; quotient and
//                     remainder are valid from the following cycle on.
//   o_quotient      : quotient register.
//   o_remainder     : remainder register.
// ----------------------------------------------------------------------------
module core_mdu_divider
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_div_start,
    input  logic                  i_div_abort,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_div_done,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0]         r_count;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_quot;      // dividend shifts out the top, quotient bits in the bottom
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_divisor;

    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;

    // Partial remainder with the next dividend bit shifted in; a clear sign
    // bit on the trial subtraction means the divisor fits.
    assign w_shift = {r_rem, r_quot[DATA_WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_div_abort) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_div_start) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_count   <= CW'(DATA_WIDTH - 1);
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            if (!w_diff[DATA_WIDTH]) begin
                r_rem  <= w_diff[DATA_WIDTH-1:0];
                r_quot <= {r_quot[DATA_WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[DATA_WIDTH-1:0];
                r_quot <= {r_quot[DATA_WIDTH-2:0], 1'b0};
            end
            if (r_count == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_div_done  = r_busy && (r_count == '0);
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule : core_mdu_divider

// File: rtl/core_mdu.sv
// ----------------------------------------------------------------------------
// core_mdu
// RV32M multiply/divide unit behind the execution stage. Multiplies take two
// cycles; divides/remainders run the iterative divider plus a sign-fix cycle.
// Divide-by-zero and signed overflow are resolved at accept time.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset.
//   mdu_start    : request strobe, honoured only in IDLE or DONE.
//   mdu_control  : operation code (instruction funct3).
//   mdu_in_a     : rs1 operand.
//   mdu_in_b     : rs2 operand.
//   mdu_kill     : pipeline flush, aborts any operation (beats mdu_start).
//   mdu_busy     : high in MUL, DIV and FIX.
//   mdu_done     : one-cycle pulse, mdu_out valid.
//   mdu_out      : result register, holds until the next result.
// ----------------------------------------------------------------------------
module core_mdu
    import core_pkg::*;
    import mdu_control_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mdu_start,
    input  logic [MDU_WIDTH_CODE-1:0] mdu_control,
    input  logic [DATA_WIDTH-1:0]     mdu_in_a,
    input  logic [DATA_WIDTH-1:0]     mdu_in_b,
    input  logic                      mdu_kill,
    output logic                      mdu_busy,
    output logic                      mdu_done,
    output logic [DATA_WIDTH-1:0]     mdu_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    localparam logic [DATA_WIDTH-1:0] W_INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    mdu_state_t            r_state;
    mdu_state_t            w_state_next;

    mdu_op_t               r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_div_start;

    mdu_op_t               w_op_in;
    logic                  w_accept;
    logic                  w_div_by_zero;
    logic                  w_overflow;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_special_result;

    logic                  w_sext_a;
    logic                  w_sext_b;
    logic [2*DATA_WIDTH-1:0] w_mul_a;
    logic [2*DATA_WIDTH-1:0] w_mul_b;
    logic [2*DATA_WIDTH-1:0] w_product;
    logic [DATA_WIDTH-1:0] w_mul_result;

    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [DATA_WIDTH-1:0] w_div_dividend;
    logic [DATA_WIDTH-1:0] w_div_divisor;
    logic                  w_div_done;
    logic [DATA_WIDTH-1:0] w_quotient;
    logic [DATA_WIDTH-1:0] w_remainder;
    logic [DATA_WIDTH-1:0] w_fix_result;

    // ------------------------------------------------------------------
    // Request decode (only meaningful when accepting)
    // ------------------------------------------------------------------
    assign w_op_in       = mdu_op_t'(mdu_control);
    assign w_accept      = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && mdu_start && !mdu_kill;
    assign w_div_by_zero = (mdu_in_b == '0);
    assign w_overflow    = is_signed_div(w_op_in) && (mdu_in_a == W_INT_MIN) && (&mdu_in_b);
    assign w_special     = is_div(w_op_in) && (w_div_by_zero || w_overflow);

    // op[1] separates remainder from quotient within the divide family.
    always_comb begin
        w_special_result = '0;
        if (w_div_by_zero) begin
            w_special_result = w_op_in[1] ? mdu_in_a : '1;
        end else begin
            w_special_result = w_op_in[1] ? '0 : W_INT_MIN;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_special) begin
                        w_state_next = ST_DONE;
                    end else if (is_div(w_op_in)) begin
                        w_state_next = ST_DIV;
                    end else begin
                        w_state_next = ST_MUL;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL:  w_state_next = ST_DONE;
            ST_DIV:  if (w_div_done) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
        if (mdu_kill) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Multiply path: 33x33 signed product realised as a 64-bit product of
    // operands extended according to the op; low 64 bits are exact.
    // ------------------------------------------------------------------
    assign w_sext_a     = (r_op == MDU_MULH) || (r_op == MDU_MULHSU);
    assign w_sext_b     = (r_op == MDU_MULH);
    assign w_mul_a      = {{DATA_WIDTH{w_sext_a & r_a[DATA_WIDTH-1]}}, r_a};
    assign w_mul_b      = {{DATA_WIDTH{w_sext_b & r_b[DATA_WIDTH-1]}}, r_b};
    assign w_product    = w_mul_a * w_mul_b;
    assign w_mul_result = (r_op == MDU_MUL) ? w_product[DATA_WIDTH-1:0]
                                            : w_product[2*DATA_WIDTH-1:DATA_WIDTH];

    // ------------------------------------------------------------------
    // Divide path: the divider sees magnitudes, signs are restored in FIX.
    // INT_MIN negates to itself, which is its correct unsigned magnitude.
    // ------------------------------------------------------------------
    assign w_neg_a        = is_signed_div(r_op) && r_a[DATA_WIDTH-1];
    assign w_neg_b        = is_signed_div(r_op) && r_b[DATA_WIDTH-1];
    assign w_div_dividend = w_neg_a ? (-r_a) : r_a;
    assign w_div_divisor  = w_neg_b ? (-r_b) : r_b;

    core_mdu_divider u_divider (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_div_start (r_div_start),
        .i_div_abort (mdu_kill),
        .i_dividend  (w_div_dividend),
        .i_divisor   (w_div_divisor),
        .o_div_done  (w_div_done),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder)
    );

    always_comb begin
        w_fix_result = '0;
        if (r_op[1]) begin
            w_fix_result = w_neg_a ? (-w_remainder) : w_remainder;
        end else begin
            w_fix_result = (w_neg_a ^ w_neg_b) ? (-w_quotient) : w_quotient;
        end
    end

    // ------------------------------------------------------------------
    // Operand latch, divider launch and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op        <= MDU_MUL;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_div_start <= 1'b0;
        end else begin
            // Divider is launched in the first DIV cycle from latched operands.
            r_div_start <= w_accept && !w_special && is_div(w_op_in);
            if (w_accept) begin
                r_op <= w_op_in;
                r_a  <= mdu_in_a;
                r_b  <= mdu_in_b;
                if (w_special) begin
                    r_out <= w_special_result;
                end
            end
            if (!mdu_kill) begin
                if (r_state == ST_MUL) begin
                    r_out <= w_mul_result;
                end else if (r_state == ST_FIX) begin
                    r_out <= w_fix_result;
                end
            end
        end
    end

    assign mdu_busy = (r_state == ST_MUL) || (r_state == ST_DIV) || (r_state == ST_FIX);
    assign mdu_done = (r_state == ST_DONE);
    assign mdu_out  = r_out;

endmodule : core_mdu

// File: tb/tb_core_mdu.sv
// ----------------------------------------------------------------------------
// tb_core_mdu
// Directed and randomized checks of core_mdu against an arithmetic reference
// model of the RV32M operations and the documented latencies.
// ----------------------------------------------------------------------------
module tb_core_mdu;

    logic        clk;
    logic        rst_n;
    logic        mdu_start;
    logic [2:0]  mdu_control;
    logic [31:0] mdu_in_a;
    logic [31:0] mdu_in_b;
    logic        mdu_kill;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] mdu_out;

    int vectors;
    int miscompares;
    logic [31:0] last_result;

    core_mdu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mdu_start   (mdu_start),
        .mdu_control (mdu_control),
        .mdu_in_a    (mdu_in_a),
        .mdu_in_b    (mdu_in_b),
        .mdu_kill    (mdu_kill),
        .mdu_busy    (mdu_busy),
        .mdu_done    (mdu_done),
        .mdu_out     (mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r  = 0;
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> 32;
            3'd2: r = (sa * ub) >>> 32;
            3'd3: r = (ua * ub) >> 32;
            3'd4: r = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? sa : sa / sb;
            3'd5: r = (b == 0) ? -1 : ua / ub;
            3'd6: r = (b == 0) ? sa : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 2;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 35;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in cycle 'start_cycle' after the accept edge (sampled #1 after it).
    task automatic wait_done(input string tag, input int start_cycle, input logic [31:0] exp, input int lat);
        int cycles;
        int busy_err;
        cycles   = start_cycle;
        busy_err = 0;
        while (!mdu_done && cycles < 60) begin
            if (mdu_busy !== 1'b1) busy_err++;
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, " done"}, 32'(mdu_done), 32'd1);
        check({tag, " latency"}, cycles, lat);
        check({tag, " result"}, mdu_out, exp);
        check({tag, " busy before done"}, busy_err, 0);
        check({tag, " busy in done"}, 32'(mdu_busy), 32'd0);
        $display("op=%0d a=%h b=%h -> out=%h (exp %h) latency=%0d", mdu_control, mdu_in_a, mdu_in_b, mdu_out, exp, cycles);
        last_result = exp;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_control = op;
        mdu_in_a    = a;
        mdu_in_b    = b;
        mdu_start   = 1'b1;
        @(posedge clk); #1;
        mdu_start   = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(tag, 1, ref_result(op, a, b), ref_latency(op, a, b));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        vectors     = 0;
        miscompares = 0;
        last_result = '0;
        rst_n       = 1'b0;
        mdu_start   = 1'b0;
        mdu_kill    = 1'b0;
        mdu_control = '0;
        mdu_in_a    = '0;
        mdu_in_b    = '0;

        idle(3);
        check("reset out", mdu_out, 32'h0);
        check("reset done", 32'(mdu_done), 32'd0);
        check("reset busy", 32'(mdu_busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed cases
        run_op("MUL 7*-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        idle(1);
        check("done pulse ends", 32'(mdu_done), 32'd0);
        run_op("MULH", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
        run_op("MULHSU", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
        run_op("MULHU", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2); idle(1);
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2); idle(1);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7); idle(1);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7); idle(1);
        run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0); idle(1);
        run_op("REM 5/0", 3'd6, 32'd5, 32'd0); idle(1);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
        run_op("DIV min/3", 3'd4, 32'h8000_0000, 32'd3); idle(1);

        // Kill at DIV cycle 10
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        idle(9);
        mdu_kill = 1'b1;
        @(posedge clk); #1;
        mdu_kill = 1'b0;
        check("kill busy", 32'(mdu_busy), 32'd0);
        check("kill done", 32'(mdu_done), 32'd0);
        check("kill out held", mdu_out, last_result);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (mdu_done) seen++; end
        check("kill no done", seen, 0);
        run_op("MUL 3*4 after kill", 3'd0, 32'd3, 32'd4); idle(1);

        // Kill beats a simultaneous start
        mdu_kill = 1'b1;
        issue(3'd0, 32'd5, 32'd6);
        mdu_kill = 1'b0;
        check("kill+start busy", 32'(mdu_busy), 32'd0);
        idle(1);
        check("kill+start done", 32'(mdu_done), 32'd0);
        check("kill+start out", mdu_out, last_result);

        // Reset mid-divide
        issue(3'd5, 32'd1000, 32'd3);
        idle(5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset out", mdu_out, 32'h0);
        check("midreset busy", 32'(mdu_busy), 32'd0);
        check("midreset done", 32'(mdu_done), 32'd0);
        rst_n = 1'b1;
        idle(1);
        run_op("MUL after reset", 3'd0, 32'd9, 32'd9); idle(1);

        // Start during DIV is ignored
        issue(3'd5, 32'd100, 32'd7);
        idle(4);
        issue(3'd0, 32'd3, 32'd4);
        mdu_control = 3'd5; mdu_in_a = 32'd100; mdu_in_b = 32'd7;
        wait_done("DIVU with ignored start", 6, 32'd14, 35);

        // Back-to-back: start in the DONE cycle
        run_op("b2b MUL 1", 3'd0, 32'd11, 32'd13);
        run_op("b2b MUL 2", 3'd0, 32'hFFFF_FFFF, 32'd5);
        run_op("b2b DIV", 3'd4, 32'd50, 32'hFFFF_FFF9);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: begin a = 32'($urandom_range(0, 500)); b = -32'($urandom_range(1, 9)); end
                default: ;
            endcase
            run_op("random", op, a, b);
            idle(int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_core_mdu
